// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared definitions for the pipeline stage registers: the
//                occupancy state encoding and the default control/data bundle
//                widths at each stage boundary of the five-stage core.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_pkg;

    // Occupancy of a stage register: no entry, main only, main plus skid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_t;

    // IF -> ID: instruction word and PC, almost no control yet.
    localparam int IF_ID_CTRL_W  = 4;
    localparam int IF_ID_DATA_W  = 64;

    // ID -> EX: full decoded control, two operands, immediate, register numbers.
    localparam int ID_EX_CTRL_W  = 16;
    localparam int ID_EX_DATA_W  = 96;

    // EX -> MEM: ALU result, store data, destination register.
    localparam int EX_MEM_CTRL_W = 8;
    localparam int EX_MEM_DATA_W = 72;

    // MEM -> WB: write-back value and destination register.
    localparam int MEM_WB_CTRL_W = 4;
    localparam int MEM_WB_DATA_W = 40;

endpackage
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_slot
//  Description : One storage entry of a pipeline stage register. Holds a
//                combined control+data word; synchronous clear wins over load.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_slot #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Entry register: zero on reset or clear, otherwise capture on load.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Generic pipeline stage register with valid/ready handshake,
//                synchronous flush (inserts a zeroed bubble) and a saturating
//                back-pressure counter. Build option PIPE_SKID_EN adds a skid
//                entry so IN_READY can be a plain register output.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = ID_EX_CTRL_W,
    parameter int DATA_W = ID_EX_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              FLUSH,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [CTRL_W-1:0] IN_CTRL,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [CTRL_W-1:0] OUT_CTRL,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [CNT_W-1:0]  STALL_CNT
);

    localparam int c_SLOT_W = CTRL_W + DATA_W;

    pipe_state_t         r_state;
    pipe_state_t         w_state_nxt;
    logic                w_xfer_in;
    logic                w_xfer_out;
    logic                w_main_load;
    logic                w_main_clr;
    logic [c_SLOT_W-1:0] w_in_slot;
    logic [c_SLOT_W-1:0] w_main_d;
    logic [c_SLOT_W-1:0] w_main_q;
    logic [CNT_W-1:0]    r_stall_cnt;

    assign w_in_slot  = {IN_CTRL, IN_DATA};
    assign OUT_VALID  = (r_state != ST_EMPTY);
    assign w_xfer_in  = IN_VALID & IN_READY;
    assign w_xfer_out = OUT_VALID & OUT_READY;

`ifdef PIPE_SKID_EN
    logic                r_in_ready;
    logic                w_skid_load;
    logic                w_skid_clr;
    logic [c_SLOT_W-1:0] w_skid_q;

    assign IN_READY = r_in_ready;
    // In FULL the main entry refills from the skid; otherwise from upstream.
    assign w_main_d = (r_state == ST_FULL) ? w_skid_q : w_in_slot;
`else
    assign IN_READY = !OUT_VALID || OUT_READY;
    assign w_main_d = w_in_slot;
`endif

    // Next-state and slot control; flush overrides every transfer.
    always_comb begin
        w_state_nxt = r_state;
        w_main_load = 1'b0;
        w_main_clr  = 1'b0;
`ifdef PIPE_SKID_EN
        w_skid_load = 1'b0;
        w_skid_clr  = 1'b0;
`endif
        if (FLUSH) begin
            w_state_nxt = ST_EMPTY;
            w_main_clr  = 1'b1;
`ifdef PIPE_SKID_EN
            w_skid_clr  = 1'b1;
`endif
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_xfer_in) begin
                        w_main_load = 1'b1;
                        w_state_nxt = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_xfer_in && w_xfer_out) begin
                        w_main_load = 1'b1;
`ifdef PIPE_SKID_EN
                    end else if (w_xfer_in) begin
                        w_skid_load = 1'b1;
                        w_state_nxt = ST_FULL;
`endif
                    end else if (w_xfer_out) begin
                        // Clearing on drain keeps the outputs zero while idle.
                        w_main_clr  = 1'b1;
                        w_state_nxt = ST_EMPTY;
                    end
                end
`ifdef PIPE_SKID_EN
                ST_FULL: begin
                    if (w_xfer_out) begin
                        w_main_load = 1'b1;
                        w_skid_clr  = 1'b1;
                        w_state_nxt = ST_BUSY;
                    end
                end
`endif
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // Occupancy state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

`ifdef PIPE_SKID_EN
    // Registered ready: accept whenever the next state leaves the skid free.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_in_ready <= 1'b1;
        end else begin
            r_in_ready <= (w_state_nxt != ST_FULL);
        end
    end

    pipe_slot #(
        .WIDTH (c_SLOT_W)
    ) u_skid_slot (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .i_clr  (w_skid_clr),
        .i_load (w_skid_load),
        .i_d    (w_in_slot),
        .o_q    (w_skid_q)
    );
`endif

    pipe_slot #(
        .WIDTH (c_SLOT_W)
    ) u_main_slot (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .i_clr  (w_main_clr),
        .i_load (w_main_load),
        .i_d    (w_main_d),
        .o_q    (w_main_q)
    );

    assign {OUT_CTRL, OUT_DATA} = w_main_q;

    // Saturating count of back-pressure cycles; only reset clears it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_stall_cnt <= '0;
        end else if (OUT_VALID && !OUT_READY && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign STALL_CNT = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_reg
//  Description : Directed self-checking bench for pipe_stage_reg (both the
//                default build and the PIPE_SKID_EN build).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int CTRL_W = 16;
    localparam int DATA_W = 96;
    localparam int CNT_W  = 4;

    logic              CLK;
    logic              RST_N;
    logic              FLUSH;
    logic              IN_VALID;
    logic              IN_READY;
    logic [CTRL_W-1:0] IN_CTRL;
    logic [DATA_W-1:0] IN_DATA;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic [CTRL_W-1:0] OUT_CTRL;
    logic [DATA_W-1:0] OUT_DATA;
    logic [CNT_W-1:0]  STALL_CNT;

    int n_checks;
    int n_pass;
    int exp_stall;

    pipe_stage_reg #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .FLUSH     (FLUSH),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_CTRL   (IN_CTRL),
        .IN_DATA   (IN_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_CTRL  (OUT_CTRL),
        .OUT_DATA  (OUT_DATA),
        .STALL_CNT (STALL_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        exp_stall = 0;
        RST_N     = 1'b0;
        FLUSH     = 1'b0;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        IN_CTRL   = '0;
        IN_DATA   = '0;

        // Reset state
        tick();
        tick();
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_out_ctrl",  OUT_CTRL,  0);
        chk("rst_out_data",  OUT_DATA,  0);
        chk("rst_stall",     STALL_CNT, 0);
        chk("rst_in_ready",  IN_READY,  1);
        RST_N = 1'b1;

        // Streaming: one entry per cycle, one cycle latency
        OUT_READY = 1'b1;
        IN_VALID  = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            IN_DATA = DATA_W'(i);
            IN_CTRL = CTRL_W'(16'h0100 + i);
            tick();
            chk("stream_valid", OUT_VALID, 1);
            chk("stream_data",  OUT_DATA,  128'(i));
            chk("stream_ctrl",  OUT_CTRL,  128'(16'h0100 + i));
            chk("stream_ready", IN_READY,  1);
        end
        IN_VALID = 1'b0;
        tick();
        chk("stream_drain_valid", OUT_VALID, 0);
        chk("stream_drain_data",  OUT_DATA,  0);
        chk("stream_drain_ctrl",  OUT_CTRL,  0);
        chk("stream_stall",       STALL_CNT, 0);

        // Back-pressure
`ifdef PIPE_SKID_EN
        OUT_READY = 1'b0;
        IN_VALID  = 1'b1;
        IN_DATA   = 'hA;
        tick();
        chk("bp_first_data",  OUT_DATA, 'hA);
        chk("bp_first_ready", IN_READY, 1);
        IN_DATA = 'hB;
        tick();
        chk("bp_hold_a",     OUT_DATA, 'hA);
        chk("bp_full_ready", IN_READY, 0);
        IN_DATA = 'hC;
        tick();
        tick();
        exp_stall = 3;
        chk("bp_still_a",    OUT_DATA,  'hA);
        chk("bp_still_full", IN_READY,  0);
        chk("bp_stall3",     STALL_CNT, 3);
        OUT_READY = 1'b1;
        tick();
        chk("bp_out_b",      OUT_DATA, 'hB);
        chk("bp_ready_back", IN_READY, 1);
        tick();
        chk("bp_out_c",      OUT_DATA, 'hC);
        IN_VALID = 1'b0;
        tick();
        chk("bp_empty",      OUT_VALID, 0);
        chk("bp_stall_keep", STALL_CNT, 3);
`else
        OUT_READY = 1'b0;
        IN_VALID  = 1'b1;
        IN_DATA   = 'hA;
        tick();
        chk("bp_first_data", OUT_DATA, 'hA);
        chk("bp_comb_low",   IN_READY, 0);
        OUT_READY = 1'b1;
        #1;
        chk("bp_comb_high",  IN_READY, 1);
        IN_DATA = 'hB;
        tick();
        chk("bp_out_b", OUT_DATA, 'hB);
        OUT_READY = 1'b0;
        IN_VALID  = 1'b0;
        tick();
        exp_stall = 1;
        chk("bp_hold_b", OUT_DATA,  'hB);
        chk("bp_stall1", STALL_CNT, 1);
        OUT_READY = 1'b1;
        tick();
        chk("bp_empty",  OUT_VALID, 0);
`endif

        // Flush with an input offered in the same cycle
        OUT_READY = 1'b0;
        IN_VALID  = 1'b1;
        IN_DATA   = 'h1;
        IN_CTRL   = 16'h0F0F;
        tick();
`ifdef PIPE_SKID_EN
        IN_DATA = 'h2;
        tick();
        exp_stall++;
        chk("fl_full", IN_READY, 0);
`else
        OUT_READY = 1'b1;
`endif
        FLUSH   = 1'b1;
        IN_DATA = 'hD;
        tick();
`ifdef PIPE_SKID_EN
        exp_stall++;
`endif
        FLUSH     = 1'b0;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        #1;
        chk("fl_valid", OUT_VALID, 0);
        chk("fl_ctrl",  OUT_CTRL,  0);
        chk("fl_data",  OUT_DATA,  0);
        chk("fl_ready", IN_READY,  1);
        chk("fl_stall", STALL_CNT, 128'(exp_stall));
        OUT_READY = 1'b1;
        tick();
        chk("fl_no_d",  OUT_VALID, 0);

        // Saturation of the back-pressure counter
        OUT_READY = 1'b0;
        IN_VALID  = 1'b1;
        IN_DATA   = 'h55;
        tick();
        IN_VALID = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            exp_stall = (exp_stall < 15) ? exp_stall + 1 : 15;
            chk("sat_stall", STALL_CNT, 128'(exp_stall));
        end
        chk("sat_final", STALL_CNT, 15);
        chk("sat_data",  OUT_DATA,  'h55);

        // Asynchronous reset mid-stream
`ifdef PIPE_SKID_EN
        IN_VALID = 1'b1;
        IN_DATA  = 'h66;
        tick();
        chk("rm_full", IN_READY, 0);
        IN_VALID = 1'b0;
`endif
        #2;
        RST_N = 1'b0;
        #1;
        chk("rm_valid", OUT_VALID, 0);
        chk("rm_data",  OUT_DATA,  0);
        chk("rm_stall", STALL_CNT, 0);
        chk("rm_ready", IN_READY,  1);
        IN_VALID  = 1'b1;
        IN_DATA   = 'h77;
        OUT_READY = 1'b1;
        tick();
        chk("rm_no_xfer", OUT_VALID, 0);
        RST_N = 1'b1;
        #1;
        tick();
        chk("rm_first_valid", OUT_VALID, 1);
        chk("rm_first_data",  OUT_DATA,  'h77);
        IN_VALID = 1'b0;
        tick();
        chk("rm_drain", OUT_VALID, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
